debug_reg_port: RTL and testbench
=================================

Name: debug_reg_port

Overview:
Debug-side register access unit for the riscv core. It is the active counterpart to passive register monitoring: it halts the core at an instruction boundary and reads or writes x0..x31 through a dedicated register-file debug port. It answers each command over a valid/ready request/response handshake. It sits between an external debug host (bench or UART bridge) and the core's stall input and register-file debug port.

Parameters:
XLEN, 32, register data width
AW, 5, register index width (32 registers)
HALT_TIMEOUT, 16, max cycles waiting for core_idle after a halt request

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
dbg_req_valid  input  1  host command valid
dbg_req_ready  output  1  unit accepts command this cycle
dbg_req_op  input  2  00 read, 01 write, 10 halt, 11 resume
dbg_req_addr  input  AW  register index
dbg_req_wdata  input  XLEN  write data
dbg_rsp_valid  output  1  response valid
dbg_rsp_ready  input  1  host accepts response
dbg_rsp_rdata  output  XLEN  read data (0 for non-read ops)
dbg_rsp_err  output  1  command failed
core_stall  output  1  freezes PC/pipeline advance
core_idle  input  1  core is at an instruction boundary with no RF write pending
rf_dbg_addr  output  AW  register-file debug index
rf_dbg_rdata  input  XLEN  combinational read of rf_dbg_addr
rf_dbg_we  output  1  register-file debug write enable (single-cycle pulse)
rf_dbg_wdata  output  XLEN  register-file debug write data
halted  output  1  core is held by debug

Behaviour:
- Clock is clk. Reset is synchronous, active-high, and named reset.
- Reset values: state RUNNING; dbg_req_ready=1; dbg_rsp_valid=0; dbg_rsp_rdata=0; dbg_rsp_err=0; core_stall=0; rf_dbg_we=0; rf_dbg_addr=0; rf_dbg_wdata=0; halted=0; timeout counter=0.
- States:
  - RUNNING: accepts commands.
  - HALTING: core_stall=1; counts cycles while waiting for core_idle.
  - HALTED: core_stall=1, halted=1; accepts commands.
  - ACCESS: one-cycle register-file access.
  - RESP: holds the response until it is accepted.
- Handshake:
  - A command is accepted when dbg_req_valid & dbg_req_ready at a rising clk edge.
  - dbg_req_ready=1 only in RUNNING and HALTED.
  - Only one command is outstanding at a time. Opcode, address and wdata are latched at acceptance.
  - A response is held stable in RESP until dbg_rsp_valid & dbg_rsp_ready. On that edge the unit returns to the pre-command run state (RUNNING or HALTED).
- Halt:
  - From RUNNING, acceptance moves to HALTING; core_stall rises on the next cycle.
  - The first cycle with core_idle=1 goes to HALTED, then RESP with err=0.
  - If HALT_TIMEOUT cycles pass without core_idle, the unit drops core_stall, returns to RUNNING, and responds with err=1.
  - Halt while already HALTED: immediate RESP with err=0.
- Resume:
  - From HALTED: core_stall and halted fall on the edge of acceptance; RESP with err=0.
  - Resume while RUNNING: RESP with err=0, no effect.
- Read and write while RUNNING: no register-file activity; RESP with err=1.
- Read while HALTED:
  - Acceptance at edge N moves to ACCESS; rf_dbg_addr is driven during cycle N+1.
  - rf_dbg_rdata is captured at edge N+2, with dbg_rsp_valid=1 from edge N+2 (latency 2).
  - Reading x0 returns 0 regardless of rf_dbg_rdata.
- Write while HALTED:
  - rf_dbg_we=1 for exactly cycle N+1, with rf_dbg_addr and rf_dbg_wdata valid.
  - The response follows at N+2 with err=0.
  - Writing x0 suppresses rf_dbg_we and still returns err=0.
- rf_dbg_we is never asserted outside ACCESS.
- halted stays 1 throughout ACCESS and RESP for commands issued while halted.
- dbg_rsp_rdata is 0 for every op except a successful read.
- dbg_req_valid in non-accepting states is ignored; the host must hold it.
- Reset mid-operation (any state, including a pending response or a stalled core) returns to reset values on the same edge. Any pending response is dropped and the core is released.

Test Plan:
- Halt with core_idle tied 1 -> core_stall=1 one cycle after acceptance, halted=1, response err=0; core's PC holds its value (e.g. 0x0000000C) across 10 cycles.
- Halted; write x5=0xDEADBEEF then read x5 -> rf_dbg_we pulses exactly once with addr=5; read response rdata=0xDEADBEEF, err=0, valid 2 cycles after acceptance.
- Halted; write x0=0x12345678 then read x0 -> rf_dbg_we never asserted; read returns 0x00000000, err=0.
- Read x1 while RUNNING -> err=1, rdata=0, rf_dbg_we stays 0, core_stall stays 0.
- Halt with core_idle held 0 -> after 16 cycles core_stall drops, halted=0, err=1; repeat with core_idle rising at cycle 3 -> halted=1, err=0.
- Halted, read pending, dbg_rsp_ready=0 for 5 cycles then reset=1 -> next cycle dbg_rsp_valid=0, core_stall=0, halted=0, dbg_req_ready=1; then resume after a fresh halt -> core_stall=0, PC advances.

Source files
------------

// File: rtl/debug_reg_port.sv
// Debug register access unit: halts the core at an instruction boundary and
// serves host read/write commands to x0..x31 over a valid/ready handshake.
module debug_reg_port #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned AW           = 5,
   parameter int unsigned HALT_TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            dbg_req_valid,
   output logic            dbg_req_ready,
   input  logic [1:0]      dbg_req_op,
   input  logic [AW-1:0]   dbg_req_addr,
   input  logic [XLEN-1:0] dbg_req_wdata,
   output logic            dbg_rsp_valid,
   input  logic            dbg_rsp_ready,
   output logic [XLEN-1:0] dbg_rsp_rdata,
   output logic            dbg_rsp_err,
   output logic            core_stall,
   input  logic            core_idle,
   output logic [AW-1:0]   rf_dbg_addr,
   input  logic [XLEN-1:0] rf_dbg_rdata,
   output logic            rf_dbg_we,
   output logic [XLEN-1:0] rf_dbg_wdata,
   output logic            halted
);
   localparam int unsigned TW = $clog2(HALT_TIMEOUT + 1);

   localparam logic [1:0] OP_READ   = 2'b00;
   localparam logic [1:0] OP_WRITE  = 2'b01;
   localparam logic [1:0] OP_HALT   = 2'b10;
   localparam logic [1:0] OP_RESUME = 2'b11;

   typedef enum logic [2:0] {
      S_RUNNING,
      S_HALTING,
      S_HALTED,
      S_ACCESS,
      S_RESP
   } state_e;

   state_e          state_q, state_d;
   logic [1:0]      op_q, op_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            hret_q, hret_d;   // run state to return to after RESP: 1 = HALTED
   logic            ph_q, ph_d;       // ACCESS phase: 0 = address setup, 1 = RF cycle
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            err_q, err_d;
   logic            we_q, we_d;
   logic            ready_q, valid_q, stall_q, halted_q;
   logic            held_d, stall_d, req_fire;

   assign req_fire = dbg_req_valid & ready_q;

   // Next-state and response datapath
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      tmo_d   = tmo_q;
      hret_d  = hret_q;
      ph_d    = ph_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      we_d    = 1'b0;

      unique case (state_q)
         S_RUNNING, S_HALTED: begin
            if (req_fire) begin
               op_d    = dbg_req_op;
               addr_d  = dbg_req_addr;
               wdata_d = dbg_req_wdata;
               rdata_d = '0;
               err_d   = 1'b0;
               hret_d  = (state_q == S_HALTED);
               unique case (dbg_req_op)
                  OP_READ, OP_WRITE: begin
                     if (state_q == S_HALTED) begin
                        state_d = S_ACCESS;
                        ph_d    = 1'b0;
                     end else begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                     end
                  end
                  OP_HALT: begin
                     if (state_q == S_HALTED) begin
                        state_d = S_RESP;
                     end else begin
                        state_d = S_HALTING;
                        tmo_d   = '0;
                     end
                  end
                  OP_RESUME: begin
                     state_d = S_RESP;
                     hret_d  = 1'b0;
                  end
                  default: state_d = S_RESP;
               endcase
            end
         end
         S_HALTING: begin
            if (core_idle) begin
               state_d = S_RESP;
               hret_d  = 1'b1;
               tmo_d   = '0;
            end else if (tmo_q == TW'(HALT_TIMEOUT - 1)) begin
               state_d = S_RESP;
               hret_d  = 1'b0;
               err_d   = 1'b1;
               tmo_d   = '0;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_ACCESS: begin
            if (!ph_q) begin
               ph_d = 1'b1;
               we_d = (op_q == OP_WRITE) && (addr_q != '0);
            end else begin
               ph_d    = 1'b0;
               state_d = S_RESP;
               rdata_d = ((op_q == OP_READ) && (addr_q != '0)) ? rf_dbg_rdata : '0;
            end
         end
         S_RESP: begin
            if (dbg_rsp_ready) begin
               state_d = hret_q ? S_HALTED : S_RUNNING;
               rdata_d = '0;
               err_d   = 1'b0;
            end
         end
         default: state_d = S_RUNNING;
      endcase

      held_d  = (state_d == S_HALTED) ||
                (((state_d == S_ACCESS) || (state_d == S_RESP)) && hret_d);
      stall_d = held_d || (state_d == S_HALTING);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_RUNNING;
         op_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         tmo_q    <= '0;
         hret_q   <= 1'b0;
         ph_q     <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         we_q     <= 1'b0;
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
         stall_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         tmo_q    <= tmo_d;
         hret_q   <= hret_d;
         ph_q     <= ph_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         we_q     <= we_d;
         ready_q  <= (state_d == S_RUNNING) || (state_d == S_HALTED);
         valid_q  <= (state_d == S_RESP);
         stall_q  <= stall_d;
         halted_q <= held_d;
      end
   end

   assign dbg_req_ready = ready_q;
   assign dbg_rsp_valid = valid_q;
   assign dbg_rsp_rdata = rdata_q;
   assign dbg_rsp_err   = err_q;
   assign core_stall    = stall_q;
   assign halted        = halted_q;
   assign rf_dbg_addr   = addr_q;
   assign rf_dbg_wdata  = wdata_q;
   assign rf_dbg_we     = we_q;

endmodule

// File: tb/tb_debug_reg_port.sv
// Self-checking bench for debug_reg_port: a small core model (register file,
// PC) plus a command-level reference model compared against the DUT each cycle.
module tb_debug_reg_port;
   localparam int unsigned XLEN         = 32;
   localparam int unsigned AW           = 5;
   localparam int          HALT_TIMEOUT = 16;

   localparam logic [1:0] OP_READ   = 2'b00;
   localparam logic [1:0] OP_WRITE  = 2'b01;
   localparam logic [1:0] OP_HALT   = 2'b10;
   localparam logic [1:0] OP_RESUME = 2'b11;

   logic            clk = 1'b0;
   logic            reset;
   logic            dbg_req_valid, dbg_req_ready;
   logic [1:0]      dbg_req_op;
   logic [AW-1:0]   dbg_req_addr;
   logic [XLEN-1:0] dbg_req_wdata;
   logic            dbg_rsp_valid, dbg_rsp_ready;
   logic [XLEN-1:0] dbg_rsp_rdata;
   logic            dbg_rsp_err;
   logic            core_stall, core_idle;
   logic [AW-1:0]   rf_dbg_addr;
   logic [XLEN-1:0] rf_dbg_rdata;
   logic            rf_dbg_we;
   logic [XLEN-1:0] rf_dbg_wdata;
   logic            halted;

   always #5 clk = ~clk;

   debug_reg_port #(.XLEN(XLEN), .AW(AW), .HALT_TIMEOUT(HALT_TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
      .dbg_req_op(dbg_req_op), .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata),
      .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready),
      .dbg_rsp_rdata(dbg_rsp_rdata), .dbg_rsp_err(dbg_rsp_err),
      .core_stall(core_stall), .core_idle(core_idle),
      .rf_dbg_addr(rf_dbg_addr), .rf_dbg_rdata(rf_dbg_rdata),
      .rf_dbg_we(rf_dbg_we), .rf_dbg_wdata(rf_dbg_wdata),
      .halted(halted)
   );

   // Core model: register file behind the debug port and a PC that advances unless stalled
   logic [XLEN-1:0] rf_mem  [32];
   logic [XLEN-1:0] init_rf [32];
   logic            load_rf;
   logic [31:0]     pc;
   int              we_cnt;

   assign rf_dbg_rdata = rf_mem[rf_dbg_addr];

   always @(posedge clk) begin
      if (load_rf) begin
         for (int i = 0; i < 32; i++) rf_mem[i] <= init_rf[i];
         pc     <= 32'h0000_000C;
         we_cnt <= 0;
      end else begin
         if (rf_dbg_we) begin
            rf_mem[rf_dbg_addr] <= rf_dbg_wdata;
            we_cnt              <= we_cnt + 1;
         end
         if (!core_stall) pc <= pc + 32'd4;
      end
   end

   // Reference model state and per-cycle expectations
   logic [XLEN-1:0] mdl_rf [32];
   logic            mdl_halted;
   logic            exp_ready, exp_valid, exp_stall, exp_halted, exp_we, exp_err;
   logic [XLEN-1:0] exp_rdata, exp_wdata;
   logic [AW-1:0]   exp_addr;
   logic            chk_en;
   logic [XLEN-1:0] last_rdata;
   logic            last_err;
   int              n_checks = 0;
   int              n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("req_ready",  32'(dbg_req_ready), 32'(exp_ready));
         check("rsp_valid",  32'(dbg_rsp_valid), 32'(exp_valid));
         check("core_stall", 32'(core_stall),    32'(exp_stall));
         check("halted",     32'(halted),        32'(exp_halted));
         check("rf_we",      32'(rf_dbg_we),     32'(exp_we));
         if (exp_we) begin
            check("rf_addr",  32'(rf_dbg_addr), 32'(exp_addr));
            check("rf_wdata", rf_dbg_wdata,     exp_wdata);
         end
         if (exp_valid) begin
            check("rsp_rdata", dbg_rsp_rdata,     exp_rdata);
            check("rsp_err",   32'(dbg_rsp_err),  32'(exp_err));
         end
      end
   end

   task automatic set_idle();
      exp_ready  = 1'b1;
      exp_valid  = 1'b0;
      exp_stall  = mdl_halted;
      exp_halted = mdl_halted;
      exp_we     = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      core_idle = 1'($urandom_range(0, 1));
   endtask

   // One command: k = HALTING cycles before core_idle rises; rst_mid resets during the response
   task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [XLEN-1:0] wd,
                          input int k, input bit rst_mid);
      logic [XLEN-1:0] e_rd;
      logic            e_err, fin_h;
      int              hold, lat;
      e_rd  = '0;
      e_err = 1'b0;
      fin_h = mdl_halted;
      dbg_req_op    = op;
      dbg_req_addr  = a;
      dbg_req_wdata = wd;
      dbg_req_valid = 1'b1;
      step();
      dbg_req_valid = 1'b0;
      dbg_req_op    = 2'($urandom_range(0, 3));
      dbg_req_addr  = 5'($urandom_range(0, 31));
      dbg_req_wdata = $urandom;
      case (op)
         OP_HALT: begin
            if (!mdl_halted) begin
               lat = (k < HALT_TIMEOUT) ? k + 1 : HALT_TIMEOUT;
               for (int t = 0; t < lat; t++) begin
                  core_idle  = (t >= k);
                  exp_ready  = 1'b0;
                  exp_valid  = 1'b0;
                  exp_stall  = 1'b1;
                  exp_halted = 1'b0;
                  exp_we     = 1'b0;
                  step();
               end
               fin_h = (k < HALT_TIMEOUT);
               e_err = !fin_h;
            end
         end
         OP_RESUME: fin_h = 1'b0;
         default: begin
            if (!mdl_halted) begin
               e_err = 1'b1;
            end else begin
               exp_ready  = 1'b0;
               exp_valid  = 1'b0;
               exp_stall  = 1'b1;
               exp_halted = 1'b1;
               exp_we     = 1'b0;
               step();
               exp_we    = (op == OP_WRITE) && (a != 0);
               exp_addr  = a;
               exp_wdata = wd;
               step();
               exp_we = 1'b0;
               if (op == OP_WRITE) begin
                  if (a != 0) mdl_rf[a] = wd;
               end else begin
                  e_rd = (a == 0) ? '0 : mdl_rf[a];
               end
            end
         end
      endcase
      mdl_halted = fin_h;
      exp_ready  = 1'b0;
      exp_valid  = 1'b1;
      exp_rdata  = e_rd;
      exp_err    = e_err;
      exp_stall  = fin_h;
      exp_halted = fin_h;
      exp_we     = 1'b0;
      last_rdata = dbg_rsp_rdata;
      last_err   = dbg_rsp_err;
      hold = rst_mid ? 5 : int'($urandom_range(0, 3));
      dbg_rsp_ready = 1'b0;
      repeat (hold) step();
      if (rst_mid) begin
         reset = 1'b1;
         step();
         reset      = 1'b0;
         mdl_halted = 1'b0;
      end else begin
         dbg_rsp_ready = 1'b1;
         step();
         dbg_rsp_ready = 1'b0;
      end
      set_idle();
   endtask

   initial begin
      #2_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      logic [31:0] saved_pc;
      int          cnt0, k;
      logic [1:0]  op;
      logic [4:0]  a;
      bit          rm;

      for (int i = 0; i < 32; i++) begin
         init_rf[i] = $urandom;
         mdl_rf[i]  = init_rf[i];
      end
      init_rf[0]    = 32'hBAD0_0000;
      reset         = 1'b1;
      load_rf       = 1'b1;
      chk_en        = 1'b0;
      dbg_req_valid = 1'b0;
      dbg_req_op    = '0;
      dbg_req_addr  = '0;
      dbg_req_wdata = '0;
      dbg_rsp_ready = 1'b0;
      core_idle     = 1'b0;
      mdl_halted    = 1'b0;
      exp_rdata     = '0;
      exp_err       = 1'b0;
      exp_addr      = '0;
      exp_wdata     = '0;
      set_idle();
      step();
      step();
      load_rf = 1'b0;
      chk_en  = 1'b1;
      check("rst_rdata",    dbg_rsp_rdata,      32'h0);
      check("rst_err",      32'(dbg_rsp_err),   32'h0);
      check("rst_rf_addr",  32'(rf_dbg_addr),   32'h0);
      check("rst_rf_wdata", rf_dbg_wdata,       32'h0);
      reset = 1'b0;
      step();

      run_cmd(OP_HALT, 5'd0, 32'h0, 0, 1'b0);
      check("halt_err",    32'(last_err), 32'h0);
      check("halt_halted", 32'(halted),   32'h1);
      saved_pc = pc;
      repeat (10) step();
      check("pc_hold", pc, saved_pc);

      cnt0 = we_cnt;
      run_cmd(OP_WRITE, 5'd5, 32'hDEADBEEF, 0, 1'b0);
      check("we_pulses_x5", 32'(we_cnt - cnt0), 32'h1);
      run_cmd(OP_READ, 5'd5, 32'h0, 0, 1'b0);
      check("rd_x5_data", last_rdata,     32'hDEADBEEF);
      check("rd_x5_err",  32'(last_err),  32'h0);

      cnt0 = we_cnt;
      run_cmd(OP_WRITE, 5'd0, 32'h12345678, 0, 1'b0);
      check("we_pulses_x0", 32'(we_cnt - cnt0), 32'h0);
      run_cmd(OP_READ, 5'd0, 32'h0, 0, 1'b0);
      check("rd_x0_data", last_rdata,    32'h0);
      check("rd_x0_err",  32'(last_err), 32'h0);

      run_cmd(OP_RESUME, 5'd0, 32'h0, 0, 1'b0);
      check("resume_halted", 32'(halted), 32'h0);
      run_cmd(OP_READ, 5'd1, 32'h0, 0, 1'b0);
      check("run_rd_err",   32'(last_err),   32'h1);
      check("run_rd_data",  last_rdata,      32'h0);
      check("run_rd_stall", 32'(core_stall), 32'h0);

      run_cmd(OP_HALT, 5'd0, 32'h0, 20, 1'b0);
      check("tmo_err",    32'(last_err),   32'h1);
      check("tmo_halted", 32'(halted),     32'h0);
      check("tmo_stall",  32'(core_stall), 32'h0);
      run_cmd(OP_HALT, 5'd0, 32'h0, 3, 1'b0);
      check("late_idle_err",    32'(last_err), 32'h0);
      check("late_idle_halted", 32'(halted),   32'h1);

      run_cmd(OP_READ, 5'd7, 32'h0, 0, 1'b1);
      check("rstmid_valid", 32'(dbg_rsp_valid), 32'h0);
      check("rstmid_stall", 32'(core_stall),    32'h0);
      check("rstmid_halt",  32'(halted),        32'h0);
      check("rstmid_ready", 32'(dbg_req_ready), 32'h1);
      run_cmd(OP_HALT, 5'd0, 32'h0, 0, 1'b0);
      run_cmd(OP_RESUME, 5'd0, 32'h0, 0, 1'b0);
      saved_pc = pc;
      repeat (3) step();
      check("pc_advance", pc - saved_pc, 32'd12);

      for (int n = 0; n < 300; n++) begin
         op = 2'($urandom_range(0, 3));
         a  = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 5) == 0) a = 5'd0;
         k  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 20))
                                          : int'($urandom_range(0, 4));
         rm = ($urandom_range(0, 39) == 0);
         run_cmd(op, a, $urandom, k, rm);
         repeat ($urandom_range(0, 2)) step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
